// File: rtl/cell_memory_pkg.sv
// cell_memory_pkg -- shared memory_unit definitions.
//
// Used by the cell memory and by the execute/traversal units that drive it.
// Holds the default geometry macros, the mem_func and mem_error codes, the
// cell word field bounds ({tag, hed, tel}) and the cell memory FSM states.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif

`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif

package cell_memory_pkg;

    // Operation requested on mem_func.
    typedef enum logic [1:0] {
        FUNC_GET   = 2'd0,
        FUNC_SET   = 2'd1,
        FUNC_ALLOC = 2'd2,
        FUNC_RSVD  = 2'd3
    } mem_func_e;

    // Sticky status reported on mem_error.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_FUNC = 2'd1,
        ERR_NO_MEM   = 2'd2
    } mem_error_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPOND
    } state_e;

    // Cell word layout: {tag[TAG_W-1:0], hed[PTR_W-1:0], tel[PTR_W-1:0]}.
    // The tag occupies the top TAG_W bits; hed and tel split the rest
    // evenly, tel in the least significant bits.
    localparam int TAG_W = 5;

    function automatic int ptr_width(input int data_w);
        return (data_w - TAG_W) / 2;
    endfunction

    function automatic int tag_lsb(input int data_w);
        return data_w - TAG_W;
    endfunction

endpackage

// File: rtl/cell_ram.sv
// cell_ram -- single-port synchronous RAM holding the cell words.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   ADDR_W  word address
//   wdata  in   DATA_W  write word
//   rdata  out  DATA_W  registered read word (value before any same-cycle write)
//
// No reset: contents survive rst, and the plain array with a registered read
// maps onto block RAM.

module cell_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cell_memory.sv
// cell_memory -- cell store with a bump allocator for the execute/traversal units.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   mem_execute  in   request strobe; a request is its rising edge
//   mem_func     in   2       GET_CONTENTS / SET_CONTENTS / ALLOC_WRITE / reserved
//   address      in   ADDR_W  target cell for GET/SET
//   write_data   in   DATA_W  word for SET/ALLOC
//   mem_ready    out  one-cycle completion pulse, two cycles after acceptance
//   read_data    out  DATA_W  read word, stored word, or allocated pointer
//   free_addr    out  ADDR_W  next unallocated cell
//   mem_error    out  2       sticky status, first error wins
//
// Sequence: IDLE (accept, RAM read issued at the accepting edge) ->
// ACCESS (read word available, writes performed, results registered) ->
// RESPOND (mem_ready high) -> IDLE.

module cell_memory
    import cell_memory_pkg::*;
#(
    parameter int ADDR_W    = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W    = `MEMORY_DATA_WIDTH,
    parameter int FREE_BASE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_execute,
    input  logic [1:0]        mem_func,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] free_addr,
    output logic [1:0]        mem_error
);

    state_e            state_reg, state_next;
    logic              exec_prev_reg;
    logic [ADDR_W-1:0] addr_reg;
    mem_func_e         func_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] read_data_reg;
    logic              mem_ready_reg;
    logic [ADDR_W-1:0] free_addr_reg;
    mem_error_e        mem_error_reg;

    logic              accept;
    logic              alloc_full;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // Only a low-to-high transition of mem_execute starts a request, so a
    // strobe held high across a whole transaction is a single request.
    assign accept     = (state_reg == ST_IDLE) && mem_execute && !exec_prev_reg;

    // The top cell is never handed out: free_addr saturates one below wrap.
    assign alloc_full = (free_addr_reg == {ADDR_W{1'b1}});

    cell_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        ram_we     = 1'b0;
        ram_addr   = address;
        case (state_reg)
            ST_IDLE: begin
                // RAM address follows the live input so a GET's word is
                // already registered out of the RAM during ACCESS.
                ram_addr = address;
                if (accept) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESPOND;
                ram_addr   = (func_reg == FUNC_ALLOC) ? free_addr_reg : addr_reg;
                ram_we     = (func_reg == FUNC_SET) ||
                             ((func_reg == FUNC_ALLOC) && !alloc_full);
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
                ram_addr   = addr_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            exec_prev_reg <= 1'b1;
            addr_reg      <= '0;
            func_reg      <= FUNC_GET;
            wdata_reg     <= '0;
            read_data_reg <= '0;
            mem_ready_reg <= 1'b0;
            free_addr_reg <= ADDR_W'(FREE_BASE);
            mem_error_reg <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            exec_prev_reg <= mem_execute;
            mem_ready_reg <= (state_reg == ST_ACCESS);

            if (accept) begin
                addr_reg  <= address;
                func_reg  <= mem_func_e'(mem_func);
                wdata_reg <= write_data;
            end

            if (state_reg == ST_ACCESS) begin
                case (func_reg)
                    FUNC_GET: begin
                        read_data_reg <= ram_rdata;
                    end
                    FUNC_SET: begin
                        read_data_reg <= wdata_reg;
                    end
                    FUNC_ALLOC: begin
                        if (alloc_full) begin
                            read_data_reg <= '0;
                            if (mem_error_reg == ERR_NONE) begin
                                mem_error_reg <= ERR_NO_MEM;
                            end
                        end else begin
                            // Pointer word: tag 0, hed 0, tel = allocated cell.
                            read_data_reg <= DATA_W'(free_addr_reg);
                            free_addr_reg <= free_addr_reg + ADDR_W'(1);
                        end
                    end
                    default: begin
                        read_data_reg <= '0;
                        if (mem_error_reg == ERR_NONE) begin
                            mem_error_reg <= ERR_BAD_FUNC;
                        end
                    end
                endcase
            end
        end
    end

    assign mem_ready = mem_ready_reg;
    assign read_data = read_data_reg;
    assign free_addr = free_addr_reg;
    assign mem_error = mem_error_reg;

endmodule

// File: tb/tb_cell_memory.sv
// tb_cell_memory -- randomized scoreboard bench for cell_memory.
//
// A driver issues requests and pushes the reference model's expected
// response into a queue; a monitor pops and compares on every mem_ready.

module tb_cell_memory;
    import cell_memory_pkg::*;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int FB    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_execute = 1'b0;
    logic [1:0]    mem_func = 2'd0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_ready;
    logic [DW-1:0] read_data;
    logic [AW-1:0] free_addr;
    logic [1:0]    mem_error;

    cell_memory #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FREE_BASE (FB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address     (address),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .read_data   (read_data),
        .free_addr   (free_addr),
        .mem_error   (mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd;
        logic [AW-1:0] fa;
        logic [1:0]    err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the memory as an array, the allocator as a counter.
    logic [DW-1:0] model_mem [DEPTH];
    int            model_free = FB;
    int            model_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_op(input logic [1:0] f, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output exp_t e);
        case (f)
            2'd0: e.rd = model_mem[a];
            2'd1: begin
                model_mem[a] = wd;
                e.rd = wd;
            end
            2'd2: begin
                if (model_free == DEPTH - 1) begin
                    e.rd = '0;
                    if (model_err == 0) model_err = 2;
                end else begin
                    model_mem[model_free] = wd;
                    e.rd = DW'(model_free);
                    model_free++;
                end
            end
            default: begin
                e.rd = '0;
                if (model_err == 0) model_err = 1;
            end
        endcase
        e.fa  = AW'(model_free);
        e.err = 2'(model_err);
    endtask

    // Monitor: compares every completion against the scoreboard and checks
    // that read_data holds between completions.
    initial begin
        exp_t e;
        logic [DW-1:0] last_rd;
        last_rd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd = '0;
            end else if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'(mem_ready), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", 64'(read_data), 64'(e.rd));
                    check("free_addr", 64'(free_addr), 64'(e.fa));
                    check("mem_error", 64'(mem_error), 64'(e.err));
                    $display("txn: rd=0x%0h free=%0d err=%0d", read_data, free_addr, mem_error);
                    last_rd = e.rd;
                end
            end else begin
                check("read_data_hold", 64'(read_data), 64'(last_rd));
            end
        end
    end

    // One request: strobe held `hold` cycles; inputs scrambled once the
    // request is in flight. Checks latency and that exactly one pulse occurs.
    task automatic do_req(input logic [1:0] f, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int hold);
        exp_t e;
        int   seen;
        int   lat;
        logic [31:0] r;
        model_op(f, a, wd, e);
        exp_q.push_back(e);
        @(negedge clk);
        mem_func    = f;
        address     = a;
        write_data  = wd;
        mem_execute = 1'b1;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                r = $urandom;
                address    = r[AW-1:0];
                write_data = r[31:16];
                mem_func   = r[5:4];
            end
            if (i >= hold) mem_execute = 1'b0;
            if (mem_ready) begin
                seen++;
                if (lat == 0) lat = i;
            end
        end
        check("latency", 64'(lat), 64'd2);
        check("ready_pulses", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(mem_ready), 64'd0);
        check({tag, "_rdata"}, 64'(read_data), 64'd0);
        check({tag, "_free"},  64'(free_addr), 64'(FB));
        check({tag, "_err"},   64'(mem_error), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_execute = 1'b0;
        model_free = FB;
        model_err  = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int seen;

        do_reset();

        // Fill every cell so later reads have known contents.
        for (int a = 0; a < DEPTH; a++) begin
            r = $urandom;
            do_req(2'd1, AW'(a), (a == 5) ? 16'h00A3 : r[15:0], 1);
        end
        do_req(2'd0, 3'd5, 16'h0, 1);
        do_req(2'd0, 3'd7, 16'h0, 4);

        // Random mix: GET, SET, ALLOC, occasional reserved code.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] f;
            int sel;
            r   = $urandom;
            sel = $urandom_range(0, 9);
            f   = (sel <= 3) ? 2'd0 : (sel <= 6) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
            do_req(f, r[AW-1:0], r[31:16], $urandom_range(1, 6));
        end

        // Allocation from reset, then bad func (first error wins over OOM).
        do_reset();
        do_req(2'd2, 3'd0, 16'h1234, 1);
        do_req(2'd2, 3'd0, 16'hBEEF, 2);
        do_req(2'd0, 3'd1, 16'h0, 1);
        do_req(2'd0, 3'd2, 16'h0, 1);
        do_req(2'd3, 3'd0, 16'h0, 1);
        do_req(2'd0, 3'd0, 16'h0, 3);
        for (int n = 0; n < 5; n++) begin
            r = $urandom;
            do_req(2'd2, 3'd0, r[15:0], 1);
        end

        // Seven allocations from reset: last is out of memory.
        do_reset();
        for (int n = 0; n < 7; n++) begin
            r = $urandom;
            do_req(2'd2, 3'd0, r[15:0], 1);
        end
        do_req(2'd3, 3'd0, 16'h0, 1);
        do_req(2'd0, 3'd6, 16'h0, 1);

        // Reset in ACCESS with the strobe still high.
        @(negedge clk);
        mem_func    = 2'd0;
        address     = 3'd3;
        mem_execute = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        model_free = FB;
        model_err  = 0;
        #1;
        check_reset_outputs("midop");
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        check("held_after_reset", 64'(seen), 64'd0);
        mem_execute = 1'b0;
        do_req(2'd0, 3'd3, 16'h0, 1);

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
